melodia_cumpleanos: RTL and testbench
=====================================

Name: melodia_cumpleanos

Overview:
- Single-clock block that plays "Happy Birthday" as a sequence of tone frequencies for a downstream tone generator (PWM/buzzer driver).
- Timing section: divides clk_divisor into one-cycle beat strobes (cambiar_nota).
- Melody section: steps through a 25-note ROM on those strobes and outputs each note's frequency in Hz as a 10-bit value.
- Sits between the system clock divider and the audio tone generator.

Parameters:
- TICKS_PER_BEAT, 600000, clk_divisor cycles per beat (about 0.5 s at 1.2 MHz); must be >= 2.
- REST_BEATS, 4, beats of silence after the last note; must be >= 1.

Ports:
- clk_divisor  input  1  divided system clock, about 1.2 MHz (832 ns period); all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cambiar_nota  output  1  one-cycle beat strobe.
- frecuencia  output  10  current note frequency in Hz; 0 means silence.
- indice_nota  output  5  current ROM index, 0..25; 25 means the rest slot.
- fin_melodia  output  1  high while in the rest slot.

Behaviour:
- All outputs are registered. The clock and the synchronous active-high reset are fixed for this block.
- Reset value of every output: tick counter 0, cambiar_nota 0, indice_nota 0, beat counter 0, frecuencia 392, fin_melodia 0.
- Tick counter:
  - Counts 0..TICKS_PER_BEAT-1, then wraps to 0.
  - cambiar_nota is high for exactly the one cycle in which the counter equals TICKS_PER_BEAT-1.
  - Consequence: the first strobe is the TICKS_PER_BEAT-th rising edge after reset deasserts, and strobes then repeat every TICKS_PER_BEAT cycles.
- Note ROM (index: Hz, beats):
  - 0 G4 392 1; 1 G4 392 1; 2 A4 440 1; 3 G4 392 1; 4 C5 523 1; 5 B4 494 2.
  - 6 G4 392 1; 7 G4 392 1; 8 A4 440 1; 9 G4 392 1; 10 D5 587 1; 11 C5 523 2.
  - 12 G4 392 1; 13 G4 392 1; 14 G5 784 1; 15 E5 659 1; 16 C5 523 1; 17 B4 494 1; 18 A4 440 2.
  - 19 F5 698 1; 20 F5 698 1; 21 E5 659 1; 22 C5 523 1; 23 D5 587 1; 24 C5 523 2.
  - 25 rest 0 REST_BEATS.
- Note advance:
  - On every strobe the beat counter increments.
  - When it reaches the current entry's beat length, the beat counter clears and indice_nota advances.
  - frecuencia and fin_melodia update in that same cycle from the new entry, so they are visible the cycle after the strobe.
- Total melody length is 29 beats; the rest slot is entered after the 29th strobe.
- reset asserted mid-note aborts the note immediately and returns every output to its reset value; the tick phase restarts from 0.
- Simultaneous reset and strobe condition: reset wins.
- Frequencies all fit in 10 bits (max 784); no arithmetic saturation is required.

Optional Feature:
- Macro: MELODIA_LOOP_EN.
- Defined: after the rest slot's REST_BEATS strobes, indice_nota returns to 0, frecuencia returns to 392, fin_melodia drops, and playback repeats forever.
- Undefined: the rest slot is terminal. frecuencia stays 0 and fin_melodia stays 1 until reset. cambiar_nota keeps pulsing and indice_nota stays at 25.

Test Plan:
- All scenarios use TICKS_PER_BEAT=4 and REST_BEATS=2.
- Reset held 3 cycles, then released -> frecuencia=392, indice_nota=0, cambiar_nota=0; first cambiar_nota pulse on the 4th edge after release, then on the 8th, 12th and so on; each pulse is exactly 1 cycle wide.
- Run 20 cycles after release -> frecuencia sequence 392, 392, 440, 392, 523; index 5 (494) is entered after the 5th strobe and holds through 2 strobes before index 6 (392).
- Full melody, checking frecuencia after each strobe -> the ROM order is reproduced exactly; after the 29th strobe (cycle 116 after release), frecuencia=0, indice_nota=25, fin_melodia=1.
- With MELODIA_LOOP_EN defined -> after strobe 31, indice_nota=0, frecuencia=392, fin_melodia=0; the second pass matches the first.
- With MELODIA_LOOP_EN undefined -> run 200 cycles past the end; frecuencia stays 0 and fin_melodia stays 1 while cambiar_nota keeps pulsing.
- Reset pulsed during index 14 (784) -> next cycle frecuencia=392, indice_nota=0; the next strobe comes 4 cycles after release.

Source files
------------

// File: rtl/melodia_cumpleanos.sv
// Plays "Happy Birthday" as a stream of 10-bit note frequencies, advancing on beat strobes.
// Define MELODIA_LOOP_EN to repeat the melody after the rest slot instead of stopping there.
module melodia_cumpleanos #(
    parameter int unsigned TICKS_PER_BEAT = 600000,
    parameter int unsigned REST_BEATS     = 4
) (
    input  logic       clk_divisor,
    input  logic       reset,
    output logic       cambiar_nota,
    output logic [9:0] frecuencia,
    output logic [4:0] indice_nota,
    output logic       fin_melodia
);

    localparam int unsigned TICK_W    = $clog2(TICKS_PER_BEAT);
    localparam int unsigned MAX_BEATS = (REST_BEATS > 2) ? REST_BEATS : 2;
    localparam int unsigned BEAT_W    = $clog2(MAX_BEATS + 1);
    localparam int unsigned FREQ_W    = 10;
    localparam int unsigned IDX_W     = 5;
    localparam logic [IDX_W-1:0] REST_IDX = IDX_W'(25);

    // Note ROM: frequency in Hz per index; the rest slot is silent.
    function automatic logic [FREQ_W-1:0] note_freq(input logic [IDX_W-1:0] idx);
        logic [FREQ_W-1:0] f;
        case (idx)
            5'd0, 5'd1, 5'd3, 5'd6, 5'd7,
            5'd9, 5'd12, 5'd13:               f = FREQ_W'(392);
            5'd2, 5'd8, 5'd18:                f = FREQ_W'(440);
            5'd4, 5'd11, 5'd16, 5'd22, 5'd24: f = FREQ_W'(523);
            5'd5, 5'd17:                      f = FREQ_W'(494);
            5'd10, 5'd23:                     f = FREQ_W'(587);
            5'd14:                            f = FREQ_W'(784);
            5'd15, 5'd21:                     f = FREQ_W'(659);
            5'd19, 5'd20:                     f = FREQ_W'(698);
            default:                          f = '0;
        endcase
        return f;
    endfunction

    // Note ROM: length in beats per index.
    function automatic logic [BEAT_W-1:0] note_beats(input logic [IDX_W-1:0] idx);
        logic [BEAT_W-1:0] n;
        case (idx)
            5'd5, 5'd11, 5'd18, 5'd24: n = BEAT_W'(2);
            REST_IDX:                  n = BEAT_W'(REST_BEATS);
            default:                   n = BEAT_W'(1);
        endcase
        return n;
    endfunction

    logic [TICK_W-1:0] tick_cnt, tick_next;
    logic [BEAT_W-1:0] beat_cnt, beat_next;
    logic [IDX_W-1:0]  idx_next;
    logic [FREQ_W-1:0] freq_next;
    logic              strobe_next, fin_next;

    // Next-state: tick phase, beat strobe, and note advance on the registered strobe.
    always_comb begin
        tick_next   = tick_cnt + TICK_W'(1);
        strobe_next = (tick_cnt == TICK_W'(TICKS_PER_BEAT - 2));
        beat_next   = beat_cnt;
        idx_next    = indice_nota;
        if (tick_cnt == TICK_W'(TICKS_PER_BEAT - 1)) begin
            tick_next = '0;
        end
        if (cambiar_nota) begin
            if ((beat_cnt + BEAT_W'(1)) == note_beats(indice_nota)) begin
                beat_next = '0;
                if (indice_nota == REST_IDX) begin
`ifdef MELODIA_LOOP_EN
                    idx_next = '0;
`else
                    idx_next = REST_IDX;
`endif
                end else begin
                    idx_next = indice_nota + IDX_W'(1);
                end
            end else begin
                beat_next = beat_cnt + BEAT_W'(1);
            end
        end
        freq_next = note_freq(idx_next);
        fin_next  = (idx_next == REST_IDX);
    end

    always_ff @(posedge clk_divisor) begin
        if (reset) begin
            tick_cnt     <= '0;
            cambiar_nota <= 1'b0;
            beat_cnt     <= '0;
            indice_nota  <= '0;
            frecuencia   <= FREQ_W'(392);
            fin_melodia  <= 1'b0;
        end else begin
            tick_cnt     <= tick_next;
            cambiar_nota <= strobe_next;
            beat_cnt     <= beat_next;
            indice_nota  <= idx_next;
            frecuencia   <= freq_next;
            fin_melodia  <= fin_next;
        end
    end

endmodule

// File: tb/tb_melodia_cumpleanos.sv
// Self-checking bench for melodia_cumpleanos with 4 ticks per beat and 2 rest beats.
module tb_melodia_cumpleanos;

    localparam int TPB  = 4;
    localparam int REST = 2;

    logic       clk_divisor;
    logic       reset;
    logic       cambiar_nota;
    logic [9:0] frecuencia;
    logic [4:0] indice_nota;
    logic       fin_melodia;

    melodia_cumpleanos #(.TICKS_PER_BEAT(TPB), .REST_BEATS(REST)) dut (
        .clk_divisor (clk_divisor),
        .reset       (reset),
        .cambiar_nota(cambiar_nota),
        .frecuencia  (frecuencia),
        .indice_nota (indice_nota),
        .fin_melodia (fin_melodia)
    );

    always #5 clk_divisor = ~clk_divisor;

    int rom_freq [26] = '{392, 392, 440, 392, 523, 494, 392, 392, 440, 392, 587, 523,
                          392, 392, 784, 659, 523, 494, 440, 698, 698, 659, 523, 587, 523, 0};
    int rom_len  [26] = '{1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2,
                          1, 1, 1, 1, 1, 2, REST};
    // Frequency sounding during each beat of one pass, written out beat by beat.
    int beat_tbl [31] = '{392, 392, 440, 392, 523, 494, 494, 392, 392, 440, 392, 587,
                          523, 523, 392, 392, 784, 659, 523, 494, 440, 440, 698, 698,
                          659, 523, 587, 523, 523, 0, 0};

    int          c;
    int          vectors;
    int          miscompares;
    logic [16:0] exp_q [$];
    logic [16:0] got;
    logic [16:0] expv;

    // Expected {cambiar_nota, frecuencia, indice_nota, fin_melodia} c edges after reset release.
    function automatic logic [16:0] model(input int cyc);
        int b, acc, idx;
        logic strobe;
        b      = cyc / TPB;
        strobe = ((cyc % TPB) == TPB - 1);
`ifdef MELODIA_LOOP_EN
        b = b % (29 + REST);
`else
        if (b > 29) b = 29;
`endif
        acc = 0;
        idx = 25;
        for (int i = 0; i < 26; i++) begin
            if (idx == 25 && i < 25 && b < acc + rom_len[i]) idx = i;
            acc += rom_len[i];
        end
        return {strobe, 10'(rom_freq[idx]), 5'(idx), (idx == 25)};
    endfunction

    function automatic int beat_freq(input int b);
`ifdef MELODIA_LOOP_EN
        return beat_tbl[b % 31];
`else
        return (b >= 29) ? 0 : beat_tbl[b];
`endif
    endfunction

    // One clock edge: queue the expectation for the resulting state, then advance.
    task automatic step(input logic rst);
        int cn;
        cn = rst ? 0 : c + 1;
        exp_q.push_back(model(cn));
        reset = rst;
        @(posedge clk_divisor);
        #1;
        c = cn;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            got = {cambiar_nota, frecuencia, indice_nota, fin_melodia};
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL reset_state cyc=%0d got=%h want=%h", i, got, expv);
            end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            got = {cambiar_nota, frecuencia, indice_nota, fin_melodia};
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL strobe_timing c=%0d got=%h want=%h", c, got, expv);
            end
            vectors++;
            if (cambiar_nota !== (c == 3 || c == 7 || c == 11)) begin
                miscompares++;
                $display("FAIL strobe_width c=%0d got=%b", c, cambiar_nota);
            end
        end
    endtask

    task automatic test_first_notes;
        while (c < 28) begin
            step(1'b0);
            got = {cambiar_nota, frecuencia, indice_nota, fin_melodia};
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL first_notes c=%0d got=%h want=%h", c, got, expv);
            end
            if (c % TPB == 0) begin
                vectors++;
                if (int'(frecuencia) != beat_freq(c / TPB)) begin
                    miscompares++;
                    $display("FAIL first_beat c=%0d got=%0d want=%0d", c, frecuencia, beat_freq(c / TPB));
                end
            end
        end
        vectors++;
        if (indice_nota !== 5'd6 || frecuencia !== 10'd392) begin
            miscompares++;
            $display("FAIL idx6_after_long_note got idx=%0d f=%0d want idx=6 f=392", indice_nota, frecuencia);
        end
    endtask

    task automatic test_full_melody;
        step(1'b1);
        void'(exp_q.pop_front());
        while (c < 116) begin
            step(1'b0);
            got = {cambiar_nota, frecuencia, indice_nota, fin_melodia};
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL full_melody c=%0d got=%h want=%h", c, got, expv);
            end
            if (c % TPB == 0) begin
                vectors++;
                if (int'(frecuencia) != beat_freq(c / TPB)) begin
                    miscompares++;
                    $display("FAIL melody_beat c=%0d got=%0d want=%0d", c, frecuencia, beat_freq(c / TPB));
                end
            end
        end
        vectors++;
        if (frecuencia !== 10'd0 || indice_nota !== 5'd25 || fin_melodia !== 1'b1) begin
            miscompares++;
            $display("FAIL melody_end got f=%0d idx=%0d fin=%b want f=0 idx=25 fin=1",
                     frecuencia, indice_nota, fin_melodia);
        end
    endtask

    task automatic test_end;
        int strobes;
        strobes = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0);
            strobes += int'(cambiar_nota);
            got = {cambiar_nota, frecuencia, indice_nota, fin_melodia};
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL after_end c=%0d got=%h want=%h", c, got, expv);
            end
            if (c % TPB == 0) begin
                vectors++;
                if (int'(frecuencia) != beat_freq(c / TPB)) begin
                    miscompares++;
                    $display("FAIL after_end_beat c=%0d got=%0d want=%0d", c, frecuencia, beat_freq(c / TPB));
                end
            end
`ifdef MELODIA_LOOP_EN
            if (c == 124) begin
                vectors++;
                if (indice_nota !== 5'd0 || frecuencia !== 10'd392 || fin_melodia !== 1'b0) begin
                    miscompares++;
                    $display("FAIL loop_restart got idx=%0d f=%0d fin=%b", indice_nota, frecuencia, fin_melodia);
                end
            end
`else
            vectors++;
            if (frecuencia !== 10'd0 || fin_melodia !== 1'b1 || indice_nota !== 5'd25) begin
                miscompares++;
                $display("FAIL terminal_rest c=%0d got f=%0d fin=%b idx=%0d", c, frecuencia, fin_melodia, indice_nota);
            end
`endif
        end
        vectors++;
        if (strobes != 50) begin
            miscompares++;
            $display("FAIL strobe_count got=%0d want=50", strobes);
        end
    endtask

    task automatic test_reset_mid_note;
        int edges;
        step(1'b1);
        void'(exp_q.pop_front());
        while (c < 65) begin
            step(1'b0);
            got = {cambiar_nota, frecuencia, indice_nota, fin_melodia};
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL to_note14 c=%0d got=%h want=%h", c, got, expv);
            end
        end
        vectors++;
        if (frecuencia !== 10'd784 || indice_nota !== 5'd14) begin
            miscompares++;
            $display("FAIL in_note14 got f=%0d idx=%0d want f=784 idx=14", frecuencia, indice_nota);
        end
        step(1'b1);
        got = {cambiar_nota, frecuencia, indice_nota, fin_melodia};
        expv = exp_q.pop_front();
        vectors++;
        if (got !== expv || frecuencia !== 10'd392 || indice_nota !== 5'd0) begin
            miscompares++;
            $display("FAIL mid_note_reset got=%h want=%h", got, expv);
        end
        edges = 0;
        while (indice_nota !== 5'd1 && edges < 20) begin
            step(1'b0);
            void'(exp_q.pop_front());
            edges++;
        end
        vectors++;
        if (edges != 4) begin
            miscompares++;
            $display("FAIL restart_latency got=%0d edges want=4", edges);
        end
        // Reset on the edge where the strobe would be consumed must win.
        step(1'b1);
        void'(exp_q.pop_front());
        while (c < 3) begin
            step(1'b0);
            void'(exp_q.pop_front());
        end
        vectors++;
        if (cambiar_nota !== 1'b1) begin
            miscompares++;
            $display("FAIL strobe_before_reset got=%b want=1", cambiar_nota);
        end
        step(1'b1);
        got = {cambiar_nota, frecuencia, indice_nota, fin_melodia};
        expv = exp_q.pop_front();
        vectors++;
        if (got !== expv || indice_nota !== 5'd0 || cambiar_nota !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wins got=%h want=%h", got, expv);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            got = {cambiar_nota, frecuencia, indice_nota, fin_melodia};
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL after_reset_wins c=%0d got=%h want=%h", c, got, expv);
            end
        end
    endtask

    initial begin
        clk_divisor = 1'b0;
        reset       = 1'b1;
        c           = 0;
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_first_notes();
        test_full_melody();
        test_end();
        test_reset_mid_note();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
